uart_rx_ctrl: RTL and testbench

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

---
 rtl/uart_rx_ctrl_pkg.sv | 13 +
 rtl/uart_rx_ctrl_fifo.sv | 83 ++++++++
 rtl/uart_rx_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_ctrl_pkg.sv
// Shared UART constants and types used by the receive controller and its FIFO.
package uart_rx_ctrl_pkg;

    localparam int UART_DEFAULT_DIV     = 868;
    localparam int UART_MIN_DIV         = 2;
    localparam int UART_RX_TIMEOUT_BITS = 40;

    typedef enum logic [0:0] {
        DIV_IDLE = 1'b0,
        DIV_PEND = 1'b1
    } type_uart_div_states_e;

endpackage : uart_rx_ctrl_pkg

// File: rtl/uart_rx_ctrl_fifo.sv
// Generic synchronous FIFO (uart_fifo); full-and-popped accepts a push, flush wins over push.
module uart_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       wdata_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    output logic [WIDTH-1:0]       rdata_o,
    output logic                   empty_o,
    output logic                   full_o,
    output logic                   push_ok_o,
    output logic                   pop_ok_o,
    output logic [$clog2(DEPTH):0] level_o,
    output logic [$clog2(DEPTH):0] level_nxt_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             do_push, do_pop;

    assign empty_o = (level_q == '0);
    assign full_o  = (level_q == LW'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    assign push_ok_o   = do_push && !flush_i;
    assign pop_ok_o    = do_pop;
    assign level_o     = level_q;
    assign level_nxt_o = level_d;
    assign rdata_o     = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            // Simultaneous push and pop leaves the occupancy unchanged, even when full.
            case ({do_push, do_pop})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok_o) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule : uart_fifo

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: byte FIFO, sticky errors, deferred baud divisor update, irq.
// Define UART_RX_TIMEOUT_EN to add the character-timeout counter and the timeout_o port.
module uart_rx_ctrl #(
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_W      = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [7:0]                  rx_data_i,
    input  logic                        rx_valid_i,
    input  logic                        rx_frame_err_i,
    input  logic                        rx_active_i,
    input  logic                        cfg_wr_i,
    input  logic [DIV_W-1:0]            cfg_div_i,
    output logic [DIV_W-1:0]            baud_div_o,
    output logic                        cfg_pend_o,
    output logic                        rd_valid_o,
    output logic [7:0]                  rd_data_o,
    input  logic                        rd_ready_i,
    input  logic                        flush_i,
    output logic [$clog2(FIFO_DEPTH):0] level_o,
    input  logic [$clog2(FIFO_DEPTH):0] watermark_i,
    output logic                        overrun_o,
    output logic                        frame_err_o,
    input  logic                        clr_err_i,
`ifdef UART_RX_TIMEOUT_EN
    output logic                        timeout_o,
`endif
    output logic                        irq_o
);

    import uart_rx_ctrl_pkg::*;

    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [DIV_W-1:0] MIN_DIV = DIV_W'(UART_MIN_DIV);
    localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(UART_DEFAULT_DIV);

    logic                  fifo_full, fifo_empty, push_ok, pop_ok;
    logic [LW-1:0]         level_q, level_d;
    logic                  overrun_q, overrun_d;
    logic                  frame_err_q, frame_err_d;
    logic                  irq_q, irq_d;
    logic                  tmo_term_d;
    type_uart_div_states_e div_state_q;
    logic [DIV_W-1:0]      baud_div_q, pend_div_q, cfg_div_clamped;
    logic                  cfg_pend_q;

    uart_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (rx_valid_i),
        .wdata_i     (rx_data_i),
        .pop_i       (rd_ready_i),
        .flush_i     (flush_i),
        .rdata_o     (rd_data_o),
        .empty_o     (fifo_empty),
        .full_o      (fifo_full),
        .push_ok_o   (push_ok),
        .pop_ok_o    (pop_ok),
        .level_o     (level_q),
        .level_nxt_o (level_d)
    );

    assign rd_valid_o  = !fifo_empty;
    assign level_o     = level_q;
    assign overrun_o   = overrun_q;
    assign frame_err_o = frame_err_q;
    assign irq_o       = irq_q;
    assign baud_div_o  = baud_div_q;
    assign cfg_pend_o  = cfg_pend_q;

    assign cfg_div_clamped = (cfg_div_i < MIN_DIV) ? MIN_DIV : cfg_div_i;

    // A byte arriving into a full FIFO is lost unless the head leaves in the same cycle.
    assign overrun_d   = (rx_valid_i && fifo_full && !pop_ok) || (overrun_q && !clr_err_i);
    assign frame_err_d = rx_frame_err_i || (frame_err_q && !clr_err_i);

    always_comb begin
        irq_d = overrun_d | frame_err_d | tmo_term_d;
        if (level_d != '0 && level_d >= watermark_i) begin
            irq_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
            irq_q       <= irq_d;
        end
    end

    // The divisor only ever moves while the receiver is idle, so no character sees two rates.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_state_q <= DIV_IDLE;
            baud_div_q  <= DEF_DIV;
            pend_div_q  <= DEF_DIV;
            cfg_pend_q  <= 1'b0;
        end else begin
            case (div_state_q)
                DIV_IDLE: begin
                    if (cfg_wr_i) begin
                        if (!rx_active_i) begin
                            baud_div_q <= cfg_div_clamped;
                        end else begin
                            pend_div_q  <= cfg_div_clamped;
                            div_state_q <= DIV_PEND;
                            cfg_pend_q  <= 1'b1;
                        end
                    end
                end
                DIV_PEND: begin
                    if (!rx_active_i) begin
                        baud_div_q  <= cfg_wr_i ? cfg_div_clamped : pend_div_q;
                        div_state_q <= DIV_IDLE;
                        cfg_pend_q  <= 1'b0;
                    end else if (cfg_wr_i) begin
                        pend_div_q <= cfg_div_clamped;
                    end
                end
                default: begin
                    div_state_q <= DIV_IDLE;
                    cfg_pend_q  <= 1'b0;
                end
            endcase
        end
    end

`ifdef UART_RX_TIMEOUT_EN
    localparam int TMO_W = $clog2(UART_RX_TIMEOUT_BITS + 1);

    logic [DIV_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             timeout_q, timeout_d;
    logic             tmo_clear;

    assign tmo_clear  = push_ok || pop_ok || flush_i || (level_q == '0);
    assign tmo_term_d = timeout_d;
    assign timeout_o  = timeout_q;

    // Bit periods are counted down from the live divisor; the count freezes once timed out.
    always_comb begin
        bit_cnt_d = bit_cnt_q;
        tmo_cnt_d = tmo_cnt_q;
        timeout_d = timeout_q;
        if (tmo_clear) begin
            bit_cnt_d = baud_div_q;
            tmo_cnt_d = '0;
            timeout_d = 1'b0;
        end else if (!timeout_q) begin
            if (bit_cnt_q <= DIV_W'(1)) begin
                bit_cnt_d = baud_div_q;
                tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                if (tmo_cnt_q == TMO_W'(UART_RX_TIMEOUT_BITS - 1)) begin
                    timeout_d = 1'b1;
                end
            end else begin
                bit_cnt_d = bit_cnt_q - DIV_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bit_cnt_q <= DEF_DIV;
            tmo_cnt_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            bit_cnt_q <= bit_cnt_d;
            tmo_cnt_q <= tmo_cnt_d;
            timeout_q <= timeout_d;
        end
    end
`else
    assign tmo_term_d = 1'b0;
`endif

endmodule : uart_rx_ctrl

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: queue-based reference model, directed scenarios, random traffic.
module tb_uart_rx_ctrl;

    localparam int DEPTH   = 16;
    localparam int DEF_DIV = 868;
`ifdef UART_RX_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_data_i;
    logic        rx_valid_i, rx_frame_err_i, rx_active_i;
    logic        cfg_wr_i;
    logic [15:0] cfg_div_i;
    logic [15:0] baud_div_o;
    logic        cfg_pend_o, rd_valid_o, rd_ready_i, flush_i;
    logic [7:0]  rd_data_o;
    logic [4:0]  level_o, watermark_i;
    logic        overrun_o, frame_err_o, clr_err_i, irq_o;
    logic        timeout_o;

    int tests = 0;
    int fails = 0;

    uart_rx_ctrl #(.FIFO_DEPTH(DEPTH), .DIV_W(16)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rx_data_i      (rx_data_i),
        .rx_valid_i     (rx_valid_i),
        .rx_frame_err_i (rx_frame_err_i),
        .rx_active_i    (rx_active_i),
        .cfg_wr_i       (cfg_wr_i),
        .cfg_div_i      (cfg_div_i),
        .baud_div_o     (baud_div_o),
        .cfg_pend_o     (cfg_pend_o),
        .rd_valid_o     (rd_valid_o),
        .rd_data_o      (rd_data_o),
        .rd_ready_i     (rd_ready_i),
        .flush_i        (flush_i),
        .level_o        (level_o),
        .watermark_i    (watermark_i),
        .overrun_o      (overrun_o),
        .frame_err_o    (frame_err_o),
        .clr_err_i      (clr_err_i),
`ifdef UART_RX_TIMEOUT_EN
        .timeout_o      (timeout_o),
`endif
        .irq_o          (irq_o)
    );

`ifndef UART_RX_TIMEOUT_EN
    assign timeout_o = 1'b0;
`endif

    always #5 clk = ~clk;

    // Reference model: the FIFO is a queue; every rule is applied per clock from the sampled inputs.
    logic [7:0] mQ[$];
    bit         mOvr, mFerr, mIrq, mPend, mTmo, modelReady;
    int         mBaud, mPendVal, mIdle;

    function automatic int clampDiv(input int d);
        return (d < 2) ? 2 : d;
    endfunction

    always @(posedge clk) begin : modelProc
        int lvl, newLvl;
        bit pop, push, ovrEvt;
        modelReady = 1'b1;
        if (!rst_n) begin
            mQ.delete();
            mOvr = 0; mFerr = 0; mIrq = 0; mPend = 0; mTmo = 0;
            mBaud = DEF_DIV; mPendVal = 0; mIdle = 0;
        end else begin
            lvl    = mQ.size();
            pop    = (lvl != 0) && rd_ready_i;
            push   = rx_valid_i && ((lvl < DEPTH) || pop) && !flush_i;
            ovrEvt = rx_valid_i && (lvl == DEPTH) && !pop;
            if (flush_i) begin
                mQ.delete();
            end else begin
                if (pop) void'(mQ.pop_front());
                if (push) mQ.push_back(rx_data_i);
            end
            if (flush_i || push || pop || lvl == 0) mIdle = 0;
            else mIdle++;
            mTmo = TMO_EN && (mIdle >= 40 * mBaud);
            mOvr  = ovrEvt || (mOvr && !clr_err_i);
            mFerr = rx_frame_err_i || (mFerr && !clr_err_i);
            if (cfg_wr_i) begin
                mPendVal = clampDiv(int'(cfg_div_i));
                mPend    = 1;
            end
            if (mPend && !rx_active_i) begin
                mBaud = mPendVal;
                mPend = 0;
            end
            newLvl = mQ.size();
            mIrq = ((newLvl != 0) && (newLvl >= int'(watermark_i))) || mOvr || mFerr || mTmo;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        if (modelReady) begin
            checkOutput("m_level", 32'(level_o), 32'(mQ.size()));
            checkOutput("m_rd_valid", 32'(rd_valid_o), 32'(mQ.size() != 0));
            if (mQ.size() != 0) checkOutput("m_rd_data", 32'(rd_data_o), 32'(mQ[0]));
            checkOutput("m_overrun", 32'(overrun_o), 32'(mOvr));
            checkOutput("m_frame_err", 32'(frame_err_o), 32'(mFerr));
            checkOutput("m_irq", 32'(irq_o), 32'(mIrq));
            checkOutput("m_baud", 32'(baud_div_o), 32'(mBaud));
            checkOutput("m_cfg_pend", 32'(cfg_pend_o), 32'(mPend));
            if (TMO_EN) checkOutput("m_timeout", 32'(timeout_o), 32'(mTmo));
        end
    end

    // Drives the data-path inputs for one clock and returns at the following falling edge.
    task automatic applyStimulus(input logic valid, input logic [7:0] data, input logic ready);
        rx_valid_i = valid;
        rx_data_i  = data;
        rd_ready_i = ready;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        rx_data_i = '0; rx_valid_i = 0; rx_frame_err_i = 0; rx_active_i = 0;
        cfg_wr_i = 0; cfg_div_i = '0; rd_ready_i = 0; flush_i = 0; clr_err_i = 0;
        watermark_i = 5'd16;
        repeat (3) @(negedge clk);
        checkOutput("reset_level", 32'(level_o), 0);
        checkOutput("reset_rd_valid", 32'(rd_valid_o), 0);
        checkOutput("reset_baud", 32'(baud_div_o), DEF_DIV);
        checkOutput("reset_pend", 32'(cfg_pend_o), 0);
        checkOutput("reset_irq", 32'(irq_o), 0);
        checkOutput("reset_overrun", 32'(overrun_o), 0);
        rst_n = 1'b1;

        // Two bytes in, held head, then drain
        applyStimulus(1, 8'hA5, 0);
        applyStimulus(1, 8'h3C, 0);
        applyStimulus(0, 8'h00, 0);
        checkOutput("two_level", 32'(level_o), 2);
        checkOutput("two_head_held", 32'(rd_data_o), 32'hA5);
        applyStimulus(0, 8'h00, 1);
        checkOutput("pop1_data", 32'(rd_data_o), 32'h3C);
        applyStimulus(0, 8'h00, 1);
        checkOutput("pop2_level", 32'(level_o), 0);
        checkOutput("pop2_valid", 32'(rd_valid_o), 0);

        // Fill, overrun, then full push+pop
        for (int i = 0; i < 16; i++) applyStimulus(1, 8'(i + 16), 0);
        checkOutput("full_level", 32'(level_o), 16);
        applyStimulus(1, 8'hFF, 0);
        checkOutput("ovr_flag", 32'(overrun_o), 1);
        checkOutput("ovr_level", 32'(level_o), 16);
        checkOutput("ovr_head", 32'(rd_data_o), 32'h10);
        applyStimulus(1, 8'hFF, 1);
        checkOutput("fullpp_level", 32'(level_o), 16);
        checkOutput("fullpp_head", 32'(rd_data_o), 32'h11);
        checkOutput("fullpp_ovr", 32'(overrun_o), 1);
        for (int i = 0; i < 15; i++) applyStimulus(0, 8'h00, 1);
        checkOutput("fullpp_tail", 32'(rd_data_o), 32'hFF);
        checkOutput("fullpp_tail_lvl", 32'(level_o), 1);
        applyStimulus(0, 8'h00, 1);
        clr_err_i = 1;
        applyStimulus(0, 8'h00, 0);
        clr_err_i = 0;
        checkOutput("clr_ovr", 32'(overrun_o), 0);

        // Deferred divisor, last write wins
        rx_active_i = 1;
        cfg_wr_i = 1; cfg_div_i = 16'h0036;
        applyStimulus(0, 8'h00, 0);
        cfg_div_i = 16'h001B;
        applyStimulus(0, 8'h00, 0);
        cfg_wr_i = 0;
        applyStimulus(0, 8'h00, 0);
        checkOutput("pend_flag", 32'(cfg_pend_o), 1);
        checkOutput("pend_baud_held", 32'(baud_div_o), DEF_DIV);
        rx_active_i = 0;
        applyStimulus(0, 8'h00, 0);
        checkOutput("apply_baud", 32'(baud_div_o), 32'h1B);
        checkOutput("apply_pend", 32'(cfg_pend_o), 0);
        cfg_wr_i = 1; cfg_div_i = 16'h0001;
        applyStimulus(0, 8'h00, 0);
        cfg_wr_i = 0;
        checkOutput("clamp_baud", 32'(baud_div_o), 2);

        // Watermark and frame-error interrupt
        watermark_i = 5'd4;
        for (int i = 0; i < 3; i++) applyStimulus(1, 8'(i + 8'h40), 0);
        checkOutput("wm_below_irq", 32'(irq_o), 0);
        applyStimulus(1, 8'h43, 0);
        checkOutput("wm_irq", 32'(irq_o), 1);
        applyStimulus(0, 8'h00, 1);
        checkOutput("wm_pop_irq", 32'(irq_o), 0);
        rx_frame_err_i = 1;
        applyStimulus(0, 8'h00, 0);
        rx_frame_err_i = 0;
        checkOutput("ferr_flag", 32'(frame_err_o), 1);
        applyStimulus(0, 8'h00, 0);
        applyStimulus(0, 8'h00, 0);
        checkOutput("ferr_irq_held", 32'(irq_o), 1);
        clr_err_i = 1;
        applyStimulus(0, 8'h00, 0);
        clr_err_i = 0;
        checkOutput("ferr_clr_irq", 32'(irq_o), 0);

        // Reset mid-operation with data queued and a divisor pending
        watermark_i = 5'd16;
        applyStimulus(1, 8'h50, 0);
        applyStimulus(1, 8'h51, 0);
        rx_active_i = 1; cfg_wr_i = 1; cfg_div_i = 16'h0040;
        applyStimulus(0, 8'h00, 0);
        cfg_wr_i = 0;
        checkOutput("pre_rst_level", 32'(level_o), 5);
        checkOutput("pre_rst_pend", 32'(cfg_pend_o), 1);
        rst_n = 0;
        applyStimulus(0, 8'h00, 1);
        checkOutput("rst_level", 32'(level_o), 0);
        checkOutput("rst_baud", 32'(baud_div_o), DEF_DIV);
        checkOutput("rst_pend", 32'(cfg_pend_o), 0);
        rst_n = 1; rx_active_i = 0;
        applyStimulus(0, 8'h00, 0);
        applyStimulus(0, 8'h00, 0);
        checkOutput("rst_no_apply", 32'(baud_div_o), DEF_DIV);

`ifdef UART_RX_TIMEOUT_EN
        cfg_wr_i = 1; cfg_div_i = 16'd4;
        applyStimulus(0, 8'h00, 0);
        cfg_wr_i = 0;
        applyStimulus(1, 8'h77, 0);
        for (int i = 0; i < 159; i++) applyStimulus(0, 8'h00, 0);
        checkOutput("tmo_159", 32'(timeout_o), 0);
        applyStimulus(0, 8'h00, 0);
        checkOutput("tmo_160", 32'(timeout_o), 1);
        applyStimulus(0, 8'h00, 1);
        checkOutput("tmo_pop", 32'(timeout_o), 0);
`endif

        // Random traffic; alternating phases bias toward filling or draining
        for (int c = 0; c < 4000; c++) begin
            int rdyPct;
            logic v;
            rdyPct = ((c / 400) % 2 == 0) ? 20 : 75;
            v = ($urandom_range(0, 99) < 55);
            rx_frame_err_i = !v && ($urandom_range(0, 99) < 2);
            flush_i        = ($urandom_range(0, 99) < 2);
            clr_err_i      = ($urandom_range(0, 99) < 4);
            cfg_wr_i       = !TMO_EN && ($urandom_range(0, 99) < 4);
            cfg_div_i      = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom_range(2, 2000));
            if ($urandom_range(0, 99) < 10) rx_active_i = !rx_active_i;
            if ($urandom_range(0, 99) < 1) watermark_i = 5'($urandom_range(0, 16));
            applyStimulus(v, 8'($urandom), ($urandom_range(0, 99) < rdyPct));
        end
        rx_frame_err_i = 0; flush_i = 0; clr_err_i = 0; cfg_wr_i = 0;
        applyStimulus(0, 8'h00, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_uart_rx_ctrl
